mdu: RTL and testbench
======================

# mdu

Iterative multiply/divide unit for the pipelined MIPS core. It accepts MULT/MULTU/DIV/DIVU requests from the ID/EXE boundary and computes over 33 clock cycles. Results go into architectural HI/LO registers. The pipeline stalls on `busy` for any MFHI/MFLO or new mul/div issued while an operation is in flight. It complements the single-cycle ALU: the ALU answers combinationally, while this block answers through a start/busy/done handshake.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width.

Ports. The block has one clock. Reset is synchronous and active-high.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high; clears all state.
- `start`  in  1  request strobe; accepted only when `busy`=0.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  WIDTH  rs operand (multiplicand / dividend).
- `b`  in  WIDTH  rt operand (multiplier / divisor).
- `hi_we`  in  1  MTHI write enable.
- `lo_we`  in  1  MTLO write enable.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse when HI/LO are updated by an operation.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States:
  - IDLE: no operation in flight.
  - RUN: iterating, with a 6-bit counter running 0..31.
  - FIX: apply signs and write back.
- Transitions: IDLE →(start) RUN →(count==31) FIX → IDLE.
- Accept edge (IDLE, start=1):
  - latch `op`;
  - latch |a| and |b| when signed, raw values when unsigned;
  - record the result signs (product sign = a[31]^b[31]; quotient sign = a[31]^b[31]; remainder sign = a[31]);
  - clear the accumulator and counter.
- MULT/MULTU: radix-2 shift-add on a 64-bit {acc, multiplier} register, one bit per cycle.
- DIV/DIVU: restoring division, one quotient bit per cycle, with a 33-bit partial remainder.
- FIX:
  - negate product/quotient/remainder as recorded;
  - mul: hi=product[63:32], lo=product[31:0];
  - div: lo=quotient, hi=remainder.
- Divide by zero: the iteration runs normally, and the result is lo=0xFFFFFFFF, hi=a (the original signed value), for both DIV and DIVU.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- `start` while `busy`=1 is ignored: no queueing, no effect on the running operation.
- MTHI/MTLO:
  - In IDLE with start=0, `hi_we`/`lo_we` write `wdata` to HI/LO on that edge.
  - With start=1 on the same edge, start wins and the write is dropped.
  - While busy, writes are ignored.
- HI/LO hold their value except on FIX or an accepted MTHI/MTLO write.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0, state IDLE, counter 0.
- Reset at any edge, including mid-RUN or in FIX, aborts the operation. The next cycle shows the reset values and there is no done pulse.
- Start accepted at edge E0. From E0, `busy`=1 for cycles E0..E33 (33 cycles).
- Edges E1..E32 perform the 32 iterations. Edge E33 is FIX.
- After E33: `busy`=0, `done`=1 for exactly one cycle, and the new `hi`/`lo` are visible in the same cycle as `done`.
- Back-to-back: a new `start` is accepted on the edge after E33, giving a throughput of one operation per 34 cycles.
- `busy` is registered; there is no combinational path from `start` to `busy`.
- MTHI/MTLO: the new value is visible the cycle after the write edge.

## Structure
- Shared package (`mdu_pkg`):
  - op encodings `MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`;
  - state encodings `MDU_IDLE`, `MDU_RUN`, `MDU_FIX`;
  - constant `MDU_ITER` = 32.
- Sub-module `mdu_divstep`: combinational, one restoring-division step (partial remainder, divisor → next remainder, quotient bit). It is instantiated once.
- Sign conditioning and the FIX negation stay in the top.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → after 34 cycles hi=0xFFFFFFFE, lo=0x00000001; done high exactly one cycle.
- MULT a=0xFFFFFFFD (−3), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=10, b=0 → lo=0xFFFFFFFF, hi=0x0000000A. A second start pulsed at E5 is ignored and the result is unchanged.
- MTHI wdata=0x12345678 in IDLE → hi=0x12345678 next cycle. Then start+lo_we on the same edge → the LO write is dropped and the operation runs.
- Reset asserted at E10 of a MULTU → next cycle busy=0, hi=lo=0, no done. A fresh MULTU 6×7 then gives lo=42, hi=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared encodings and constants for the multiply/divide unit
//
// Contents:
//   mdu_op_e    : request opcodes (MULT, MULTU, DIV, DIVU)
//   mdu_state_e : controller states (IDLE, RUN, FIX)
//   MDU_ITER    : iterations per operation (one result bit each)
//   mdu_is_div / mdu_is_signed : opcode decode helpers

package mdu_pkg;

   typedef enum logic [1:0] {
      MDU_MULT  = 2'b00,
      MDU_MULTU = 2'b01,
      MDU_DIV   = 2'b10,
      MDU_DIVU  = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      MDU_IDLE = 2'b00,
      MDU_RUN  = 2'b01,
      MDU_FIX  = 2'b10
   } mdu_state_e;

   localparam int MDU_ITER = 32;

   // Bit 1 of the opcode selects divide, bit 0 selects unsigned.
   function automatic logic mdu_is_div(input logic [1:0] op);
      return op[1];
   endfunction

   function automatic logic mdu_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/mdu_divstep.sv
// rtl/mdu_divstep.sv - one combinational restoring-division step
//
// Ports:
//   rem      in  WIDTH  current partial remainder (always < divisor)
//   bit_in   in  1      next dividend bit shifted into the remainder
//   divisor  in  WIDTH  divisor magnitude
//   rem_next out WIDTH  partial remainder after this step
//   qbit     out 1      quotient bit produced by this step

module mdu_divstep #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             bit_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic             qbit
);

   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] diff;
   logic             unused_diff_bit;

   // The shifted remainder needs WIDTH+1 bits; an extra borrow bit on the
   // subtraction tells whether the divisor fits. Whichever value is kept is
   // below the divisor, so it always fits back into WIDTH bits.
   always_comb begin
      shifted  = {rem, bit_in};
      diff     = {1'b0, shifted} - {2'b00, divisor};
      qbit     = ~diff[WIDTH+1];
      rem_next = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
   end

   assign unused_diff_bit = diff[WIDTH];

endmodule

// File: rtl/mdu.sv
// rtl/mdu.sv - iterative multiply/divide unit with architectural HI/LO
//
// Ports:
//   clock  in  1      rising-edge clock
//   reset  in  1      synchronous active-high reset, clears all state
//   start  in  1      request strobe, accepted only while busy=0
//   op     in  2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a      in  WIDTH  rs operand (multiplicand / dividend)
//   b      in  WIDTH  rt operand (multiplier / divisor)
//   hi_we  in  1      MTHI write enable (IDLE and start=0 only)
//   lo_we  in  1      MTLO write enable (IDLE and start=0 only)
//   wdata  in  WIDTH  MTHI/MTLO data
//   busy   out 1      operation in flight
//   done   out 1      one-cycle pulse when an operation updates HI/LO
//   hi     out WIDTH  HI register
//   lo     out WIDTH  LO register

module mdu
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   mdu_state_e state, state_next;

   logic [5:0]       cnt;
   logic [1:0]       op_r;
   logic [WIDTH-1:0] mcand;    // multiplicand or divisor magnitude
   logic [WIDTH-1:0] mq;       // multiplier shifting out / quotient shifting in
   logic [WIDTH-1:0] acc;      // product high half or partial remainder
   logic [WIDTH-1:0] a_orig;   // original dividend, returned in HI on divide by zero
   logic             neg_p;    // negate product / quotient at FIX
   logic             neg_r;    // negate remainder at FIX

   logic             sgn_in;
   logic [WIDTH-1:0] a_abs, b_abs;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] rem_next;
   logic             qbit;
   logic [2*WIDTH-1:0] prod, prod_s;
   logic [WIDTH-1:0] q_s, r_s;

   // ---------------- controller ----------------
   always_ff @(posedge clock) begin
      if (reset) state <= MDU_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         MDU_IDLE: if (start) state_next = MDU_RUN;
         MDU_RUN:  if (cnt == 6'(MDU_ITER - 1)) state_next = MDU_FIX;
         MDU_FIX:  state_next = MDU_IDLE;
         default:  state_next = MDU_IDLE;
      endcase
   end

   // Derived from the state register only, so start never reaches busy
   // combinationally.
   assign busy = (state != MDU_IDLE);

   // ---------------- operand conditioning ----------------
   always_comb begin
      sgn_in = mdu_is_signed(op);
      a_abs  = (sgn_in && a[WIDTH-1]) ? -a : a;
      b_abs  = (sgn_in && b[WIDTH-1]) ? -b : b;
   end

   // ---------------- iteration datapath ----------------
   // Shift-add: add the multiplicand when the multiplier LSB is set, then
   // shift {carry, acc, mq} right by one.
   assign sum = {1'b0, acc} + (mq[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});

   mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
      .rem      (acc),
      .bit_in   (mq[WIDTH-1]),
      .divisor  (mcand),
      .rem_next (rem_next),
      .qbit     (qbit)
   );

   always_comb begin
      prod   = {acc, mq};
      prod_s = neg_p ? -prod : prod;
      q_s    = neg_p ? -mq : mq;
      r_s    = neg_r ? -acc : acc;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt    <= '0;
         op_r   <= '0;
         mcand  <= '0;
         mq     <= '0;
         acc    <= '0;
         a_orig <= '0;
         neg_p  <= 1'b0;
         neg_r  <= 1'b0;
         done   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            MDU_IDLE: begin
               if (start) begin
                  op_r   <= op;
                  mcand  <= b_abs;
                  mq     <= a_abs;
                  acc    <= '0;
                  a_orig <= a;
                  neg_p  <= sgn_in & (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_r  <= sgn_in & a[WIDTH-1];
                  cnt    <= '0;
               end else begin
                  if (hi_we) hi <= wdata;
                  if (lo_we) lo <= wdata;
               end
            end
            MDU_RUN: begin
               cnt <= cnt + 6'd1;
               if (mdu_is_div(op_r)) begin
                  acc <= rem_next;
                  mq  <= {mq[WIDTH-2:0], qbit};
               end else begin
                  acc <= sum[WIDTH:1];
                  mq  <= {sum[0], mq[WIDTH-1:1]};
               end
            end
            MDU_FIX: begin
               done <= 1'b1;
               cnt  <= '0;
               if (mdu_is_div(op_r)) begin
                  // mcand holds |b|, which is zero exactly when b was zero.
                  if (mcand == '0) begin
                     lo <= '1;
                     hi <= a_orig;
                  end else begin
                     lo <= q_s;
                     hi <= r_s;
                  end
               end else begin
                  hi <= prod_s[2*WIDTH-1:WIDTH];
                  lo <= prod_s[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - self-checking bench for the multiply/divide unit

module tb_mdu;

   logic        clock = 1'b0;
   logic        reset, start, hi_we, lo_we;
   logic [1:0]  op;
   logic [31:0] a, b, wdata;
   logic        busy, done;
   logic [31:0] hi, lo;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   mdu #(.WIDTH(32)) dut (
      .clock (clock),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .hi_we (hi_we),
      .lo_we (lo_we),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Drive start for the edge E0; returns at the negedge after E0.
   task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      @(negedge clock);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clock);
      start = 1'b0;
   endtask

   // Counts negedges with busy=1 until done is seen; bounded.
   task automatic wait_done(input string name, output int cycles);
      cycles = 0;
      while (!done && cycles < 100) begin
         if (busy) cycles++;
         @(negedge clock);
      end
      if (!done) begin
         bad++; total++;
         $display("FAIL %s_timeout actual=no_done required=done", name);
      end
   endtask

   initial begin
      int cyc;
      int ndone;

      vecs[0] = '{"multu_max",   2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[1] = '{"mult_neg3x5", 2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
      vecs[2] = '{"div_m7_2",    2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3] = '{"div_ovf",     2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[4] = '{"divu_by0",    2'b11, 32'h0000000A, 32'h00000000, 32'h0000000A, 32'hFFFFFFFF};
      vecs[5] = '{"div_by0_neg", 2'b10, 32'h80000000, 32'h00000000, 32'h80000000, 32'hFFFFFFFF};
      vecs[6] = '{"divu_100_7",  2'b11, 32'd100,      32'd7,        32'd2,        32'd14};
      vecs[7] = '{"div_7_m2",    2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
      vecs[8] = '{"mult_min2",   2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[9] = '{"multu_6x7",   2'b01, 32'd6,        32'd7,        32'd0,        32'd42};

      reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      op = 2'b00; a = '0; b = '0; wdata = '0;
      repeat (2) @(negedge clock);
      check("rst_hi", hi, 32'h0);
      check("rst_lo", lo, 32'h0);
      check("rst_busy", {31'b0, busy}, 32'h0);
      check("rst_done", {31'b0, done}, 32'h0);
      reset = 1'b0;

      // Table-driven operations with latency and done-width checks.
      for (int i = 0; i < 10; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b);
         wait_done(vecs[i].name, cyc);
         check({vecs[i].name, "_busy_cycles"}, cyc, 33);
         check({vecs[i].name, "_busy_at_done"}, {31'b0, busy}, 32'h0);
         check({vecs[i].name, "_hi"}, hi, vecs[i].hi);
         check({vecs[i].name, "_lo"}, lo, vecs[i].lo);
         @(negedge clock);
         check({vecs[i].name, "_done_width"}, {31'b0, done}, 32'h0);
      end

      // A second start at E5 must not disturb a running DIVU 10/0.
      issue(2'b11, 32'h0000000A, 32'h00000000);
      repeat (4) @(negedge clock);
      start = 1'b1; op = 2'b01; a = 32'h11111111; b = 32'h22222222;
      @(negedge clock);
      start = 1'b0;
      wait_done("restart", cyc);
      check("restart_busy_cycles", cyc, 28);
      check("restart_hi", hi, 32'h0000000A);
      check("restart_lo", lo, 32'hFFFFFFFF);
      @(negedge clock);
      check("restart_no_second_done", {31'b0, done | busy}, 32'h0);

      // MTHI / MTLO in IDLE.
      hi_we = 1'b1; wdata = 32'h12345678;
      @(negedge clock);
      hi_we = 1'b0;
      check("mthi", hi, 32'h12345678);
      lo_we = 1'b1; wdata = 32'hCAFEF00D;
      @(negedge clock);
      lo_we = 1'b0;
      check("mtlo", lo, 32'hCAFEF00D);
      check("mtlo_keeps_hi", hi, 32'h12345678);

      // start + lo_we on the same edge: start wins, write dropped.
      @(negedge clock);
      start = 1'b1; lo_we = 1'b1; wdata = 32'hDEADBEEF; op = 2'b01; a = 32'd6; b = 32'd7;
      @(negedge clock);
      start = 1'b0; lo_we = 1'b0;
      check("start_wins_busy", {31'b0, busy}, 32'h1);
      check("start_wins_lo", lo, 32'hCAFEF00D);
      // A write while busy is ignored.
      hi_we = 1'b1; wdata = 32'hAAAAAAAA;
      @(negedge clock);
      hi_we = 1'b0;
      check("busy_write_ignored", hi, 32'h12345678);
      wait_done("start_wins", cyc);
      check("start_wins_res_lo", lo, 32'd42);
      check("start_wins_res_hi", hi, 32'd0);

      // Reset at E10 of a MULTU aborts it.
      issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
      repeat (9) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("abort_busy", {31'b0, busy}, 32'h0);
      check("abort_hi", hi, 32'h0);
      check("abort_lo", lo, 32'h0);
      check("abort_done", {31'b0, done}, 32'h0);
      ndone = 0;
      repeat (40) begin
         @(negedge clock);
         if (done || busy) ndone++;
      end
      check("abort_quiet", ndone, 0);

      issue(2'b01, 32'd6, 32'd7);
      wait_done("after_abort", cyc);
      check("after_abort_cycles", cyc, 33);
      check("after_abort_lo", lo, 32'd42);
      check("after_abort_hi", hi, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
